gcd_job_ctrl: RTL and testbench
===============================

// Module: gcd_job_ctrl
// PURPOSE
//  Sequences one GCD job through the rv32i core.
//  - Takes the debounced start pulse and latches the two 8-bit switch operands.
//  - Hands them to the core with a one-cycle go strobe, then waits for cpu_done.
//  - Captures the result for the LED and 7-segment path; guards against a hung core with a timeout.
//  - Sits between key_debounce and rv32i_cpu in the Basys3 top.
// PARAMETERS
//  OPW       8          operand width from switches; zero-extended to 32 bits
//  TIMEOUT   1_000_000  max cycles in WAIT before abort (>=2)
//  CNTW      16         completed-job counter width
// PORTS
//  clk           in   1     system clock, 100 MHz
//  rst           in   1     synchronous reset, active-high
//  start         in   1     one-cycle start pulse from debouncer
//  op_a          in   OPW   operand A (sw_in[15:8])
//  op_b          in   OPW   operand B (sw_in[7:0])
//  cpu_go        out  1     one-cycle job-issue strobe to core
//  cpu_abort     out  1     one-cycle abort strobe to core on timeout
//  cpu_a         out  32    latched operand A, zero-extended
//  cpu_b         out  32    latched operand B, zero-extended
//  cpu_done      in   1     core finished; cpu_result valid this cycle
//  cpu_result    in   32    core GCD result
//  result        out  32    last good GCD result, held
//  result_valid  out  1     one-cycle pulse when result updates
//  busy          out  1     high whenever state != IDLE
//  err_timeout   out  1     sticky; last job timed out
//  job_count     out  CNTW  completed jobs; wraps at 2^CNTW
// BEHAVIOUR
//  Reset (sync, rst=1 at posedge):
//    state=IDLE; cpu_a, cpu_b, result, job_count=0; all strobes, busy, err_timeout=0.
//  FSM states: IDLE, ISSUE, WAIT.
//  IDLE:
//    - start=1 at edge N: latch op_a/op_b into cpu_a/cpu_b and clear err_timeout.
//    - If both latched operands are nonzero: go to ISSUE at N+1.
//  ISSUE:
//    - cpu_go=1 for exactly this one cycle; go to WAIT. Timeout counter cleared.
//  WAIT:
//    - Counter increments each cycle.
//    - cpu_done=1: register cpu_result into result, pulse result_valid, job_count++, go to IDLE.
//      result is visible on the cycle after the done sample.
//    - Counter reaches TIMEOUT-1 with cpu_done=0: pulse cpu_abort, set err_timeout, go to IDLE.
//      result and job_count are unchanged.
//    - cpu_done and expiry in the same cycle: done wins, no error.
//  Zero bypass (IDLE start with a latched operand ==0):
//    - No cpu_go. At N+1: result = a|b (gcd(0,x)=x, gcd(0,0)=0), result_valid pulses, job_count++.
//    - State stays IDLE.
//  Ignored inputs:
//    - cpu_done outside WAIT is ignored.
//    - start while busy is dropped, unless the optional feature below is compiled in.
//  Latency: start -> cpu_go = 1 cycle; cpu_done -> result_valid = 1 cycle.
//  Reset mid-job returns to IDLE immediately. No strobe fires on the reset cycle.
// CONFIGURATION
//  GCD_CTRL_PENDING_EN defined:
//    - A start pulse while busy stores op_a/op_b into a one-entry pending slot.
//    - Later starts overwrite the slot (last wins).
//    - On return to IDLE, a valid slot is issued as if start had arrived that cycle; the slot clears.
//    - Reset clears the slot.
//  GCD_CTRL_PENDING_EN undefined:
//    - Starts while busy are silently dropped. No pending storage is built.
// TESTING
//  1 rst 3 cycles -> all outputs 0, busy=0.
//  2 op_a=36, op_b=24, start; model done with 42 after 10 cycles
//    -> cpu_go at N+1, cpu_a=36, cpu_b=24, result=42 and result_valid one cycle after done, job_count=1.
//  3 op_a=0, op_b=17, start -> no cpu_go, result=17 at N+1, busy stays 0;
//    op_a=op_b=0 -> result=0.
//  4 TIMEOUT=16, never assert done -> cpu_abort and err_timeout after 16 WAIT cycles, result unchanged;
//    next start clears err_timeout.
//  5 done coincident with final timeout cycle -> result updates, err_timeout=0;
//    stray cpu_done in IDLE -> no effect.
//  6 start during WAIT (A=9, B=6)
//    -> PENDING_EN off: dropped, job_count +1 only.
//    -> PENDING_EN on: second cpu_go the cycle after return to IDLE, cpu_a=9, cpu_b=6.
//    -> rst asserted in WAIT -> IDLE next cycle, no result_valid.

Source files
------------

// File: rtl/gcd_job_ctrl_if.sv
// Core-side job bus between gcd_job_ctrl (master) and the rv32i core (slave).
// Carries the issue/abort strobes and the zero-extended operands toward the
// core, and the completion flag plus GCD result back from it.
interface gcd_job_ctrl_if;
  logic        cpu_go;
  logic        cpu_abort;
  logic [31:0] cpu_a;
  logic [31:0] cpu_b;
  logic        cpu_done;
  logic [31:0] cpu_result;

  modport master (
    output cpu_go, cpu_abort, cpu_a, cpu_b,
    input  cpu_done, cpu_result
  );

  modport slave (
    input  cpu_go, cpu_abort, cpu_a, cpu_b,
    output cpu_done, cpu_result
  );
endinterface

// File: rtl/gcd_job_ctrl.sv
// gcd_job_ctrl: sequences one GCD job through the rv32i core.
// Latches the switch operands on a start pulse, issues a one-cycle go strobe,
// waits for the core's done flag (bounded by a timeout that aborts the core),
// and holds the last good result for the display path. Jobs with a zero
// operand are answered locally without involving the core.
// Optional build macro: GCD_CTRL_PENDING_EN -- adds a one-entry slot that
// remembers a start arriving while busy and issues it on return to IDLE.
module gcd_job_ctrl #(
  parameter int OPW     = 8,
  parameter int TIMEOUT = 1_000_000,
  parameter int CNTW    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_start,
  input  logic [OPW-1:0]      i_op_a,
  input  logic [OPW-1:0]      i_op_b,
  gcd_job_ctrl_if.master      cpu,
  output logic [31:0]         o_result,
  output logic                o_result_valid,
  output logic                o_busy,
  output logic                o_err_timeout,
  output logic [CNTW-1:0]     o_job_count
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] CNT_LAST = TW'(TIMEOUT - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;

  logic [1:0]      r_state;
  logic [TW-1:0]   r_cnt;
  logic [31:0]     r_cpu_a;
  logic [31:0]     r_cpu_b;
  logic [31:0]     r_result;
  logic            r_result_valid;
  logic            r_abort;
  logic            r_err_timeout;
  logic [CNTW-1:0] r_job_count;

  logic            w_idle;
  logic            w_take;
  logic [OPW-1:0]  w_a;
  logic [OPW-1:0]  w_b;
  logic            w_zero;
  logic            w_done;
  logic            w_expire;

  assign w_idle = (r_state == IDLE);

`ifdef GCD_CTRL_PENDING_EN
  logic           r_pend_vld;
  logic [OPW-1:0] r_pend_a;
  logic [OPW-1:0] r_pend_b;

  // A fresh start in IDLE is newer than anything parked, so it takes priority.
  assign w_take = w_idle && (i_start || r_pend_vld);
  assign w_a    = i_start ? i_op_a : r_pend_a;
  assign w_b    = i_start ? i_op_b : r_pend_b;

  // Pending slot: park the latest start seen while busy, drop it once issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend_vld <= 1'b0;
      r_pend_a   <= '0;
      r_pend_b   <= '0;
    end else if (!w_idle && i_start) begin
      r_pend_vld <= 1'b1;
      r_pend_a   <= i_op_a;
      r_pend_b   <= i_op_b;
    end else if (w_take) begin
      r_pend_vld <= 1'b0;
    end
  end
`else
  assign w_take = w_idle && i_start;
  assign w_a    = i_op_a;
  assign w_b    = i_op_b;
`endif

  assign w_zero   = (w_a == '0) || (w_b == '0);
  assign w_done   = (r_state == WAIT) && cpu.cpu_done;
  assign w_expire = (r_state == WAIT) && !cpu.cpu_done && (r_cnt == CNT_LAST);

  // Job sequencer: state, operand latches, result capture and status strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= IDLE;
      r_cpu_a        <= '0;
      r_cpu_b        <= '0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
      r_abort        <= 1'b0;
      r_err_timeout  <= 1'b0;
      r_job_count    <= '0;
    end else begin
      r_result_valid <= 1'b0;
      r_abort        <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_take) begin
            r_cpu_a       <= 32'(w_a);
            r_cpu_b       <= 32'(w_b);
            r_err_timeout <= 1'b0;
            if (w_zero) begin
              // gcd(0,x) = x and gcd(0,0) = 0, so the OR is the answer.
              r_result       <= 32'(w_a | w_b);
              r_result_valid <= 1'b1;
              r_job_count    <= r_job_count + CNTW'(1);
            end else begin
              r_state <= ISSUE;
            end
          end
        end
        ISSUE: begin
          r_state <= WAIT;
        end
        WAIT: begin
          if (w_done) begin
            r_result       <= cpu.cpu_result;
            r_result_valid <= 1'b1;
            r_job_count    <= r_job_count + CNTW'(1);
            r_state        <= IDLE;
          end else if (w_expire) begin
            r_abort       <= 1'b1;
            r_err_timeout <= 1'b1;
            r_state       <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Timeout counter: zeroed while issuing, counts every WAIT cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (r_state == ISSUE) begin
      r_cnt <= '0;
    end else if (r_state == WAIT) begin
      r_cnt <= r_cnt + TW'(1);
    end
  end

  assign cpu.cpu_go    = (r_state == ISSUE);
  assign cpu.cpu_abort = r_abort;
  assign cpu.cpu_a     = r_cpu_a;
  assign cpu.cpu_b     = r_cpu_b;

  assign o_result       = r_result;
  assign o_result_valid = r_result_valid;
  assign o_busy         = !w_idle;
  assign o_err_timeout  = r_err_timeout;
  assign o_job_count    = r_job_count;

endmodule

// File: tb/tb_gcd_job_ctrl.sv
// Directed testbench for gcd_job_ctrl. Inputs change on the falling edge and
// outputs are sampled on the falling edge, half a cycle after the DUT's
// active rising edge. TIMEOUT is shortened to 16 for the timeout scenarios.
module tb_gcd_job_ctrl;

  localparam int OPW  = 8;
  localparam int CNTW = 16;

  logic            clk;
  logic            rst;
  logic            start;
  logic [OPW-1:0]  op_a;
  logic [OPW-1:0]  op_b;
  logic [31:0]     result;
  logic            result_valid;
  logic            busy;
  logic            err_timeout;
  logic [CNTW-1:0] job_count;

  int n_pass;
  int n_tot;

  gcd_job_ctrl_if bus ();

  gcd_job_ctrl #(.OPW(OPW), .TIMEOUT(16), .CNTW(CNTW)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_start        (start),
    .i_op_a         (op_a),
    .i_op_b         (op_b),
    .cpu            (bus),
    .o_result       (result),
    .o_result_valid (result_valid),
    .o_busy         (busy),
    .o_err_timeout  (err_timeout),
    .o_job_count    (job_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    n_tot++; if (bus.cpu_go !== 1'b0) $display("FAIL rst_go got=%0d exp=0", bus.cpu_go); else n_pass++;
    n_tot++; if (bus.cpu_abort !== 1'b0) $display("FAIL rst_abort got=%0d exp=0", bus.cpu_abort); else n_pass++;
    n_tot++; if (bus.cpu_a !== 32'd0 || bus.cpu_b !== 32'd0) $display("FAIL rst_ab got=%0d/%0d exp=0/0", bus.cpu_a, bus.cpu_b); else n_pass++;
    n_tot++; if (result !== 32'd0) $display("FAIL rst_result got=%0d exp=0", result); else n_pass++;
    n_tot++; if (result_valid !== 1'b0 || busy !== 1'b0 || err_timeout !== 1'b0) $display("FAIL rst_flags got=%0d%0d%0d exp=000", result_valid, busy, err_timeout); else n_pass++;
    n_tot++; if (job_count !== 16'd0) $display("FAIL rst_count got=%0d exp=0", job_count); else n_pass++;
  endtask

  task automatic test_normal_job();
    op_a = 8'd36; op_b = 8'd24; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_tot++; if (bus.cpu_go !== 1'b1) $display("FAIL job_go got=%0d exp=1", bus.cpu_go); else n_pass++;
    n_tot++; if (bus.cpu_a !== 32'd36 || bus.cpu_b !== 32'd24) $display("FAIL job_ops got=%0d/%0d exp=36/24", bus.cpu_a, bus.cpu_b); else n_pass++;
    n_tot++; if (busy !== 1'b1) $display("FAIL job_busy got=%0d exp=1", busy); else n_pass++;
    @(negedge clk);
    n_tot++; if (bus.cpu_go !== 1'b0) $display("FAIL job_go_once got=%0d exp=0", bus.cpu_go); else n_pass++;
    repeat (8) @(negedge clk);
    bus.cpu_done = 1'b1; bus.cpu_result = 32'd42;
    @(negedge clk);
    bus.cpu_done = 1'b0; bus.cpu_result = 32'd0;
    n_tot++; if (result !== 32'd42 || result_valid !== 1'b1) $display("FAIL job_result got=%0d v=%0d exp=42 v=1", result, result_valid); else n_pass++;
    n_tot++; if (job_count !== 16'd1 || busy !== 1'b0) $display("FAIL job_count got=%0d busy=%0d exp=1 busy=0", job_count, busy); else n_pass++;
    @(negedge clk);
    n_tot++; if (result_valid !== 1'b0 || result !== 32'd42) $display("FAIL job_hold got=%0d v=%0d exp=42 v=0", result, result_valid); else n_pass++;
  endtask

  task automatic test_zero_bypass();
    op_a = 8'd0; op_b = 8'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_tot++; if (result !== 32'd0 || result_valid !== 1'b1) $display("FAIL zz_result got=%0d v=%0d exp=0 v=1", result, result_valid); else n_pass++;
    n_tot++; if (job_count !== 16'd2) $display("FAIL zz_count got=%0d exp=2", job_count); else n_pass++;
    op_a = 8'd0; op_b = 8'd17; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_tot++; if (bus.cpu_go !== 1'b0 || busy !== 1'b0) $display("FAIL zb_nogo go=%0d busy=%0d exp=0/0", bus.cpu_go, busy); else n_pass++;
    n_tot++; if (result !== 32'd17 || result_valid !== 1'b1) $display("FAIL zb_result got=%0d v=%0d exp=17 v=1", result, result_valid); else n_pass++;
    n_tot++; if (job_count !== 16'd3 || bus.cpu_b !== 32'd17) $display("FAIL zb_count got=%0d b=%0d exp=3 b=17", job_count, bus.cpu_b); else n_pass++;
    @(negedge clk);
    n_tot++; if (bus.cpu_go !== 1'b0 || busy !== 1'b0) $display("FAIL zb_idle go=%0d busy=%0d exp=0/0", bus.cpu_go, busy); else n_pass++;
  endtask

  task automatic test_timeout();
    op_a = 8'd5; op_b = 8'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (16) @(negedge clk);
    n_tot++; if (busy !== 1'b1 || bus.cpu_abort !== 1'b0) $display("FAIL to_early busy=%0d abort=%0d exp=1/0", busy, bus.cpu_abort); else n_pass++;
    @(negedge clk);
    n_tot++; if (bus.cpu_abort !== 1'b1 || err_timeout !== 1'b1) $display("FAIL to_abort abort=%0d err=%0d exp=1/1", bus.cpu_abort, err_timeout); else n_pass++;
    n_tot++; if (result !== 32'd17 || job_count !== 16'd3 || result_valid !== 1'b0) $display("FAIL to_keep got=%0d cnt=%0d v=%0d exp=17 cnt=3 v=0", result, job_count, result_valid); else n_pass++;
    n_tot++; if (busy !== 1'b0) $display("FAIL to_idle busy=%0d exp=0", busy); else n_pass++;
    @(negedge clk);
    n_tot++; if (bus.cpu_abort !== 1'b0 || err_timeout !== 1'b1) $display("FAIL to_sticky abort=%0d err=%0d exp=0/1", bus.cpu_abort, err_timeout); else n_pass++;
    op_a = 8'd7; op_b = 8'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_tot++; if (err_timeout !== 1'b0 || result !== 32'd7 || job_count !== 16'd4) $display("FAIL to_clear err=%0d got=%0d cnt=%0d exp=0 7 4", err_timeout, result, job_count); else n_pass++;
  endtask

  task automatic test_done_vs_timeout();
    op_a = 8'd12; op_b = 8'd8; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (16) @(negedge clk);
    bus.cpu_done = 1'b1; bus.cpu_result = 32'd4;
    @(negedge clk);
    bus.cpu_done = 1'b0; bus.cpu_result = 32'd0;
    n_tot++; if (result !== 32'd4 || result_valid !== 1'b1) $display("FAIL race_result got=%0d v=%0d exp=4 v=1", result, result_valid); else n_pass++;
    n_tot++; if (err_timeout !== 1'b0 || bus.cpu_abort !== 1'b0) $display("FAIL race_noerr err=%0d abort=%0d exp=0/0", err_timeout, bus.cpu_abort); else n_pass++;
    n_tot++; if (job_count !== 16'd5) $display("FAIL race_count got=%0d exp=5", job_count); else n_pass++;
    @(negedge clk);
    bus.cpu_done = 1'b1; bus.cpu_result = 32'd99;
    @(negedge clk);
    bus.cpu_done = 1'b0; bus.cpu_result = 32'd0;
    n_tot++; if (result !== 32'd4 || result_valid !== 1'b0 || job_count !== 16'd5) $display("FAIL stray_done got=%0d v=%0d cnt=%0d exp=4 v=0 cnt=5", result, result_valid, job_count); else n_pass++;
  endtask

  task automatic test_back_to_back();
    op_a = 8'd20; op_b = 8'd15; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    op_a = 8'd9; op_b = 8'd6; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_tot++; if (bus.cpu_a !== 32'd20 || busy !== 1'b1) $display("FAIL b2b_hold a=%0d busy=%0d exp=20/1", bus.cpu_a, busy); else n_pass++;
    repeat (3) @(negedge clk);
    bus.cpu_done = 1'b1; bus.cpu_result = 32'd5;
    @(negedge clk);
    bus.cpu_done = 1'b0; bus.cpu_result = 32'd0;
    n_tot++; if (result !== 32'd5 || job_count !== 16'd6 || busy !== 1'b0) $display("FAIL b2b_done got=%0d cnt=%0d busy=%0d exp=5 6 0", result, job_count, busy); else n_pass++;
    @(negedge clk);
`ifdef GCD_CTRL_PENDING_EN
    n_tot++; if (bus.cpu_go !== 1'b1 || bus.cpu_a !== 32'd9 || bus.cpu_b !== 32'd6) $display("FAIL b2b_pend go=%0d a=%0d b=%0d exp=1 9 6", bus.cpu_go, bus.cpu_a, bus.cpu_b); else n_pass++;
    @(negedge clk);
`else
    n_tot++; if (bus.cpu_go !== 1'b0 || busy !== 1'b0 || bus.cpu_a !== 32'd20) $display("FAIL b2b_drop go=%0d busy=%0d a=%0d exp=0 0 20", bus.cpu_go, busy, bus.cpu_a); else n_pass++;
    op_a = 8'd9; op_b = 8'd6; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_tot++; if (bus.cpu_go !== 1'b1 || bus.cpu_a !== 32'd9) $display("FAIL b2b_reissue go=%0d a=%0d exp=1 9", bus.cpu_go, bus.cpu_a); else n_pass++;
    @(negedge clk);
`endif
    n_tot++; if (busy !== 1'b1) $display("FAIL mid_wait busy=%0d exp=1", busy); else n_pass++;
    rst = 1'b1; bus.cpu_done = 1'b1; bus.cpu_result = 32'd77;
    @(negedge clk);
    rst = 1'b0; bus.cpu_done = 1'b0; bus.cpu_result = 32'd0;
    n_tot++; if (busy !== 1'b0 || result_valid !== 1'b0 || bus.cpu_go !== 1'b0) $display("FAIL mid_rst busy=%0d v=%0d go=%0d exp=0 0 0", busy, result_valid, bus.cpu_go); else n_pass++;
    n_tot++; if (result !== 32'd0 || job_count !== 16'd0 || bus.cpu_a !== 32'd0) $display("FAIL mid_rst_clr got=%0d cnt=%0d a=%0d exp=0 0 0", result, job_count, bus.cpu_a); else n_pass++;
    @(negedge clk);
    n_tot++; if (bus.cpu_go !== 1'b0 || busy !== 1'b0) $display("FAIL post_rst go=%0d busy=%0d exp=0/0", bus.cpu_go, busy); else n_pass++;
  endtask

  initial begin
    n_pass = 0;
    n_tot  = 0;
    rst = 1'b1; start = 1'b0; op_a = '0; op_b = '0;
    bus.cpu_done = 1'b0; bus.cpu_result = 32'd0;
    @(negedge clk);
    test_reset();
    test_normal_job();
    test_zero_bypass();
    test_timeout();
    test_done_vs_timeout();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
